// File: rtl/op_queue.sv
// op_queue: pending-request FIFO between the trace parser and the DRAM
// scheduler. The rising edge of op_ready_s enqueues {opcode, address, cycle}.
// The oldest entry, its enqueue time and its age are shown combinationally.
// The scheduler pops that entry with deq.
//
// Ports
//   clk, rst_n     clock (posedge), asynchronous active-low reset
//   op_ready_s     new-op strobe; only its low->high edge is a request
//   opcode,address operation accompanying the strobe (NOP requests ignored)
//   deq            pop the head entry this cycle
//   head_*         oldest entry (all zero / NOP when empty)
//   head_age       cycle - head_time, modulo 2^TIME_WIDTH
//   count          occupancy; queue_full / queue_empty derived from it
//   overflow       sticky: a request was dropped because the queue was full

package global_defs;
  typedef enum logic [1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } parsed_op_t;
endpackage

module op_queue
  import global_defs::*;
#(
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = 33,
  parameter int TIME_WIDTH    = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             op_ready_s,
  input  parsed_op_t                       opcode,
  input  logic [ADDRESS_WIDTH-1:0]         address,
  input  logic                             deq,
  output logic                             head_valid,
  output parsed_op_t                       head_opcode,
  output logic [ADDRESS_WIDTH-1:0]         head_address,
  output logic [TIME_WIDTH-1:0]            head_time,
  output logic [TIME_WIDTH-1:0]            head_age,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             queue_full,
  output logic                             queue_empty,
  output logic                             overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Entry storage; not reset, validity comes from r_count alone.
  parsed_op_t               r_mem_op   [DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_mem_addr [DEPTH];
  logic [TIME_WIDTH-1:0]    r_mem_time [DEPTH];

  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [TIME_WIDTH-1:0] r_cycle;
  logic                  r_strobe_prev;
  logic                  r_overflow;

  logic          w_empty, w_full, w_req, w_wr, w_deq, w_drop;
  logic [CW-1:0] w_count_nxt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_req   = op_ready_s && !r_strobe_prev && (opcode != NOP);
  // deq is only effective with something to pop. When the queue is full,
  // that pop frees the slot that the simultaneous request then takes.
  assign w_deq   = deq && !w_empty;
  assign w_wr    = w_req && (!w_full || deq);
  assign w_drop  = w_req && w_full && !deq;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_deq})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_cycle       <= '0;
      r_strobe_prev <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_cycle       <= r_cycle + TIME_WIDTH'(1);
      r_strobe_prev <= op_ready_s;
      r_count       <= w_count_nxt;
      if (w_wr)   r_wr_ptr   <= r_wr_ptr + PW'(1);
      if (w_deq)  r_rd_ptr   <= r_rd_ptr + PW'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_op[r_wr_ptr]   <= opcode;
      r_mem_addr[r_wr_ptr] <= address;
      r_mem_time[r_wr_ptr] <= r_cycle;
    end
  end

  always_comb begin
    head_opcode  = NOP;
    head_address = '0;
    head_time    = '0;
    head_age     = '0;
    if (!w_empty) begin
      head_opcode  = r_mem_op[r_rd_ptr];
      head_address = r_mem_addr[r_rd_ptr];
      head_time    = r_mem_time[r_rd_ptr];
      // Unsigned subtraction wraps, so the age stays correct after r_cycle wraps.
      head_age     = r_cycle - r_mem_time[r_rd_ptr];
    end
  end

  assign head_valid  = !w_empty;
  assign count       = r_count;
  assign queue_full  = w_full;
  assign queue_empty = w_empty;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_op_queue.sv
module tb_op_queue;
  import global_defs::*;

  localparam int DEPTH = 16;
  localparam int AW    = 33;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          op_ready_s = 1'b0;
  parsed_op_t    opcode = NOP;
  logic [AW-1:0] address = '0;
  logic          deq = 1'b0;

  logic          head_valid, queue_full, queue_empty, overflow;
  parsed_op_t    head_opcode;
  logic [AW-1:0] head_address;
  logic [31:0]   head_time, head_age;
  logic [4:0]    count;

  logic          hv8, full8, empty8, ovf8;
  parsed_op_t    hop8;
  logic [AW-1:0] haddr8;
  logic [7:0]    htime8, hage8;
  logic [4:0]    cnt8;

  always #5 clk = ~clk;

  op_queue #(.DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .TIME_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .op_ready_s(op_ready_s), .opcode(opcode),
    .address(address), .deq(deq), .head_valid(head_valid),
    .head_opcode(head_opcode), .head_address(head_address),
    .head_time(head_time), .head_age(head_age), .count(count),
    .queue_full(queue_full), .queue_empty(queue_empty), .overflow(overflow)
  );

  // Narrow-timestamp copy for the counter-wrap case.
  op_queue #(.DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .TIME_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .op_ready_s(op_ready_s), .opcode(opcode),
    .address(address), .deq(deq), .head_valid(hv8),
    .head_opcode(hop8), .head_address(haddr8),
    .head_time(htime8), .head_age(hage8), .count(cnt8),
    .queue_full(full8), .queue_empty(empty8), .overflow(ovf8)
  );

  // Cycle number that the DUT stamps on an entry enqueued at the next posedge.
  logic [31:0] tb_cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_cyc <= 32'd0;
    else        tb_cyc <= tb_cyc + 32'd1;

  typedef struct {
    parsed_op_t    op;
    logic [AW-1:0] a;
    logic [31:0]   t;
  } ent_t;

  typedef struct {
    bit            s;
    parsed_op_t    op;
    logic [AW-1:0] a;
    bit            d;
    int            exp_cnt;
  } vec_t;

  ent_t sb[$];
  bit   exp_ovf = 1'b0;
  bit   tb_prev = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_state();
    logic [31:0] age;
    chk("count", 64'(count), 64'(sb.size()));
    chk("head_valid", 64'(head_valid), 64'(sb.size() != 0));
    chk("queue_empty", 64'(queue_empty), 64'(sb.size() == 0));
    chk("queue_full", 64'(queue_full), 64'(sb.size() == DEPTH));
    chk("overflow", 64'(overflow), 64'(exp_ovf));
    if (sb.size() != 0) begin
      age = tb_cyc - sb[0].t;
      chk("head_opcode", 64'(head_opcode), 64'(sb[0].op));
      chk("head_address", 64'(head_address), 64'(sb[0].a));
      chk("head_time", 64'(head_time), 64'(sb[0].t));
      chk("head_age", 64'(head_age), 64'(age));
    end else begin
      chk("head_opcode_empty", 64'(head_opcode), 64'(NOP));
      chk("head_address_empty", 64'(head_address), 64'd0);
    end
  endtask

  // Called at a negedge: drive, predict, clock once, check at the next negedge.
  task automatic step(input bit s, input parsed_op_t op, input logic [AW-1:0] a, input bit d);
    bit   req, popped;
    ent_t e;
    op_ready_s = s; opcode = op; address = a; deq = d;
    req    = s && !tb_prev && (op != NOP);
    popped = 1'b0;
    if (d && sb.size() != 0) begin
      void'(sb.pop_front());
      popped = 1'b1;
    end
    if (req) begin
      if (sb.size() < DEPTH) begin
        e.op = op; e.a = a; e.t = tb_cyc;
        sb.push_back(e);
      end else begin
        exp_ovf = 1'b1;
      end
    end
    tb_prev = s;
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  task automatic enq(input parsed_op_t op, input logic [AW-1:0] a);
    step(1'b1, op, a, 1'b0);
    step(1'b0, NOP, '0, 1'b0);
  endtask

  task automatic do_reset();
    deq   = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_head_valid", 64'(head_valid), 64'd0);
    chk("rst_empty", 64'(queue_empty), 64'd1);
    chk("rst_full", 64'(queue_full), 64'd0);
    chk("rst_head_addr", 64'(head_address), 64'd0);
    sb.delete();
    exp_ovf = 1'b0;
    tb_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[20];

  initial begin
    // Pulse at cycle 5, a held strobe, a NOP request, and simultaneous enqueue and deq on an empty queue.
    tbl[0]  = '{1'b0, NOP,   33'h0,           1'b0, 0};
    tbl[1]  = '{1'b0, NOP,   33'h0,           1'b0, 0};
    tbl[2]  = '{1'b0, NOP,   33'h0,           1'b0, 0};
    tbl[3]  = '{1'b0, NOP,   33'h0,           1'b0, 0};
    tbl[4]  = '{1'b0, NOP,   33'h0,           1'b0, 0};
    tbl[5]  = '{1'b1, READ,  33'h1_0000_0040, 1'b0, 1};
    tbl[6]  = '{1'b0, NOP,   33'h0,           1'b1, 0};
    tbl[7]  = '{1'b1, WRITE, 33'h80,          1'b0, 1};
    tbl[8]  = '{1'b1, WRITE, 33'h80,          1'b0, 1};
    tbl[9]  = '{1'b1, WRITE, 33'h80,          1'b0, 1};
    tbl[10] = '{1'b1, WRITE, 33'h80,          1'b0, 1};
    tbl[11] = '{1'b0, NOP,   33'h0,           1'b0, 1};
    tbl[12] = '{1'b1, WRITE, 33'h84,          1'b0, 2};
    tbl[13] = '{1'b0, NOP,   33'h0,           1'b1, 1};
    tbl[14] = '{1'b0, NOP,   33'h0,           1'b1, 0};
    tbl[15] = '{1'b0, NOP,   33'h0,           1'b1, 0};
    tbl[16] = '{1'b1, READ,  33'h200,         1'b1, 1};
    tbl[17] = '{1'b0, NOP,   33'h0,           1'b0, 1};
    tbl[18] = '{1'b1, NOP,   33'h300,         1'b0, 1};
    tbl[19] = '{1'b0, NOP,   33'h0,           1'b1, 0};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].s, tbl[i].op, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].exp_cnt));
      if (i == 5) begin
        chk("first_head_time", 64'(head_time), 64'd5);
        chk("first_head_age", 64'(head_age), 64'd1);
        chk("first_head_addr", 64'(head_address), 64'h1_0000_0040);
      end
    end

    // Fill to DEPTH, overflow on the 17th request, then drain in order.
    do_reset();
    for (int k = 0; k < DEPTH; k++) enq((k % 2) ? WRITE : READ, AW'(k));
    chk("fill_full", 64'(queue_full), 64'd1);
    enq(WRITE, AW'(16));
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd16);
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("pop_order%0d", k), 64'(head_address), 64'(k));
      step(1'b0, NOP, '0, 1'b1);
    end
    chk("drained_empty", 64'(queue_empty), 64'd1);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Full queue: simultaneous request and deq.
    do_reset();
    for (int k = 0; k < DEPTH; k++) enq(READ, AW'(32'h40 + k));
    step(1'b1, WRITE, 33'h999, 1'b1);
    chk("fulldeq_count", 64'(count), 64'd16);
    chk("fulldeq_ovf", 64'(overflow), 64'd0);
    step(1'b0, NOP, '0, 1'b0);
    for (int k = 0; k < DEPTH - 1; k++) step(1'b0, NOP, '0, 1'b1);
    chk("fulldeq_tail_addr", 64'(head_address), 64'h999);
    chk("fulldeq_tail_op", 64'(head_opcode), 64'(WRITE));
    step(1'b0, NOP, '0, 1'b1);

    // A strobe already high when reset is released is an edge.
    op_ready_s = 1'b1; opcode = READ; address = 33'h55;
    do_reset();
    step(1'b1, READ, 33'h55, 1'b0);
    chk("release_edge_count", 64'(count), 64'd1);
    step(1'b0, NOP, '0, 1'b0);

    // Reset mid-stream with entries pending and overflow set.
    for (int k = 0; k < DEPTH; k++) enq(WRITE, AW'(32'h1000 + k));
    chk("pre_reset_ovf", 64'(overflow), 64'd1);
    step(1'b0, NOP, '0, 1'b0);
    op_ready_s = 1'b0; opcode = NOP; address = '0;
    do_reset();

    // 8-bit timestamp wrap: enqueue at cycle 250 and hold the head to cycle 260.
    for (int k = 0; k < 300 && tb_cyc != 32'd250; k++) step(1'b0, NOP, '0, 1'b0);
    chk("wrap_reach_250", 64'(tb_cyc), 64'd250);
    step(1'b1, READ, 33'h77, 1'b0);
    for (int k = 0; k < 9; k++) step(1'b0, NOP, '0, 1'b0);
    chk("wrap_age8", 64'(hage8), 64'd10);
    chk("wrap_time8", 64'(htime8), 64'd250);
    chk("wrap_valid8", 64'(hv8), 64'd1);
    chk("wrap_age32", 64'(head_age), 64'd10);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
